// File: rtl/lsu_dmem_master.sv
// Load/store unit master: turns one core load/store request into word-wide data memory accesses.
// Build option LSU_MISALIGN_EN: misaligned half/word accesses, split across two words when they cross.
module lsu_dmem_master #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [31:0]           req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [3:0]            mem_wstrb,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [1:0]            dbg_state
);

`ifdef LSU_MISALIGN_EN
  localparam int SPAN = 8;
`else
  localparam int SPAN = 4;
`endif
  localparam int SPAN_BITS = 8 * SPAN;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC0 = 2'd1,
`ifdef LSU_MISALIGN_EN
    ACC1 = 2'd2,
`endif
    RESP = 2'd3
  } state_t;

  state_t                state_q;
  logic [31:0]           addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [1:0]            size_q;
  logic                  we_q;
  logic                  uns_q;
`ifdef LSU_MISALIGN_EN
  logic [31:0]           rbuf_q;
`endif
  logic                  mem_we_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_wdata_q;
  logic [3:0]            mem_wstrb_q;
  logic                  resp_valid_q;
  logic [DATA_WIDTH-1:0] resp_rdata_q;
  logic                  resp_err_q;

  // In IDLE the live request is decoded; afterwards the captured copy is.
  logic [31:0]           src_addr;
  logic [DATA_WIDTH-1:0] src_wdata;
  logic [1:0]            src_size;
  logic                  src_uns;
  logic [1:0]            off;
  logic [2:0]            nbytes;
  logic [3:0]            bmask;
  logic [31:0]           wmask;
  logic [32:0]           last_addr;
  logic                  addr_err;
  logic                  misalign;
  logic                  req_err;
  logic [SPAN-1:0]       strb_sh;
  logic [SPAN_BITS-1:0]  wdata_sh;
  logic [SPAN_BITS-1:0]  lbuf;
  logic [31:0]           lshift;
  logic [31:0]           load_val;
`ifdef LSU_MISALIGN_EN
  logic                  crosses;
`endif

  always_comb begin
    src_addr  = (state_q == IDLE) ? req_addr     : addr_q;
    src_wdata = (state_q == IDLE) ? req_wdata    : wdata_q;
    src_size  = (state_q == IDLE) ? req_size     : size_q;
    src_uns   = (state_q == IDLE) ? req_unsigned : uns_q;
    off       = src_addr[1:0];
    case (src_size)
      2'b00:   begin nbytes = 3'd1; bmask = 4'b0001; wmask = {24'b0, src_wdata[7:0]};  end
      2'b01:   begin nbytes = 3'd2; bmask = 4'b0011; wmask = {16'b0, src_wdata[15:0]}; end
      default: begin nbytes = 3'd4; bmask = 4'b1111; wmask = src_wdata;                end
    endcase
  end

  // The last accessed byte lies at or above the first, so it alone bounds the range.
  assign last_addr = {1'b0, src_addr} + {30'b0, nbytes} - 33'd1;
  assign addr_err  = (last_addr >> ADDR_WIDTH) != 33'd0;
`ifdef LSU_MISALIGN_EN
  assign misalign  = 1'b0;
  assign crosses   = ({1'b0, off} + nbytes) > 3'd4;
  assign lbuf      = (state_q == ACC1) ? {mem_rdata, rbuf_q} : {32'b0, mem_rdata};
`else
  assign misalign  = ((src_size == 2'b01) && off[0]) || ((src_size == 2'b10) && (off != 2'b00));
  assign lbuf      = mem_rdata;
`endif
  assign req_err   = (src_size == 2'b11) || addr_err || misalign;
  assign strb_sh   = SPAN'(bmask) << off;
  assign wdata_sh  = SPAN_BITS'(wmask) << {off, 3'b000};
  assign lshift    = 32'(lbuf >> {off, 3'b000});

  always_comb begin
    case (src_size)
      2'b00:   load_val = src_uns ? {24'b0, lshift[7:0]}  : {{24{lshift[7]}}, lshift[7:0]};
      2'b01:   load_val = src_uns ? {16'b0, lshift[15:0]} : {{16{lshift[15]}}, lshift[15:0]};
      default: load_val = lshift;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      size_q       <= '0;
      we_q         <= 1'b0;
      uns_q        <= 1'b0;
`ifdef LSU_MISALIGN_EN
      rbuf_q       <= '0;
`endif
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_wstrb_q  <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            size_q  <= req_size;
            we_q    <= req_we;
            uns_q   <= req_unsigned;
            if (req_err) begin
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              resp_rdata_q <= '0;
            end else begin
              state_q     <= ACC0;
              mem_we_q    <= req_we;
              mem_addr_q  <= {src_addr[ADDR_WIDTH-1:2], 2'b00};
              mem_wstrb_q <= req_we ? strb_sh[3:0] : 4'b0000;
              mem_wdata_q <= req_we ? wdata_sh[31:0] : '0;
            end
          end
        end
        ACC0: begin
`ifdef LSU_MISALIGN_EN
          if (crosses) begin
            state_q     <= ACC1;
            rbuf_q      <= mem_rdata;
            mem_addr_q  <= mem_addr_q + ADDR_WIDTH'(4);
            mem_wstrb_q <= we_q ? strb_sh[7:4] : 4'b0000;
            mem_wdata_q <= we_q ? wdata_sh[63:32] : '0;
          end else
`endif
          begin
            state_q      <= RESP;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_wstrb_q  <= '0;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= we_q ? '0 : load_val;
          end
        end
`ifdef LSU_MISALIGN_EN
        ACC1: begin
          state_q      <= RESP;
          mem_we_q     <= 1'b0;
          mem_addr_q   <= '0;
          mem_wdata_q  <= '0;
          mem_wstrb_q  <= '0;
          resp_valid_q <= 1'b1;
          resp_err_q   <= 1'b0;
          resp_rdata_q <= we_q ? '0 : load_val;
        end
`endif
        RESP: begin
          state_q      <= IDLE;
          resp_valid_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Handshake: a request transfers on a posedge with req_valid && req_ready; req_ready is high only in IDLE.
  assign req_ready  = (state_q == IDLE) && rst_n;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_wstrb  = mem_wstrb_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_lsu_dmem_master.sv
// Bench for lsu_dmem_master: byte-array reference model, expected-response and expected-access queues.
// Expectations follow LSU_MISALIGN_EN when the bench is built with it.
module tb_lsu_dmem_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic [1:0]  dbg_state;

  typedef struct packed {logic err; logic [31:0] rdata; logic [31:0] cyc;} resp_t;
  typedef struct packed {logic we; logic [9:0] addr; logic [3:0] strb; logic [31:0] wdata;} acc_t;

  resp_t       exp_q[$];
  acc_t        acc_q[$];
  logic [7:0]  ref_mem[1024];
  logic [31:0] mem_words[256];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [31:0] last_rdata = '0;
  logic        last_err = 1'b0;

  lsu_dmem_master #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rdata(mem_rdata), .dbg_state(dbg_state)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Data memory: combinational read, byte-strobed write on posedge
  assign mem_rdata = mem_words[mem_addr[9:2]];
  always @(posedge clk) begin
    if (mem_we) begin
      for (int l = 0; l < 4; l++)
        if (mem_wstrb[l]) mem_words[mem_addr[9:2]][8*l +: 8] = mem_wdata[8*l +: 8];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Reference model: byte-addressed memory, size/alignment/range rules, expected accesses.
  task automatic model_req(input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           output logic err, output int lat, output logic [31:0] rdata);
    int          nb;
    longint      last;
    int          first_word;
    int          b;
    int          lane;
    bit          split;
    acc_t        a0;
    acc_t        a1;
    logic [31:0] val;
    nb   = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    last = longint'(addr) + longint'(nb) - 1;
    err  = (size == 2'd3) || (last >= 1024);
`ifndef LSU_MISALIGN_EN
    if ((addr % nb) != 0) err = 1'b1;
`endif
    rdata = '0;
    lat   = 1;
    if (err) return;
    first_word = int'(addr) & ~3;
    a0.we = we; a0.addr = 10'(first_word);     a0.strb = '0; a0.wdata = '0;
    a1.we = we; a1.addr = 10'(first_word + 4); a1.strb = '0; a1.wdata = '0;
    split = 1'b0;
    val   = '0;
    for (int i = 0; i < nb; i++) begin
      b    = int'(addr) + i;
      lane = b % 4;
      if ((b & ~3) != first_word) split = 1'b1;
      if (we) begin
        if ((b & ~3) == first_word) begin
          a0.strb[lane] = 1'b1; a0.wdata[8*lane +: 8] = wdata[8*i +: 8];
        end else begin
          a1.strb[lane] = 1'b1; a1.wdata[8*lane +: 8] = wdata[8*i +: 8];
        end
        ref_mem[b] = wdata[8*i +: 8];
      end else begin
        val[8*i +: 8] = ref_mem[b];
      end
    end
    acc_q.push_back(a0);
    if (split) acc_q.push_back(a1);
    lat = split ? 3 : 2;
    if (!we) begin
      if (nb == 1)      rdata = uns ? {24'b0, val[7:0]}  : {{24{val[7]}}, val[7:0]};
      else if (nb == 2) rdata = uns ? {16'b0, val[15:0]} : {{16{val[15]}}, val[15:0]};
      else              rdata = val;
    end
  endtask

  // Driver: one request, expected response queued with its expected cycle, then bounded drain.
  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata);
    logic        err;
    int          lat;
    logic [31:0] rdata;
    resp_t       e;
    @(negedge clk);
    chk("req_ready_idle", req_ready, 1);
    model_req(we, size, uns, addr, wdata, err, lat, rdata);
    req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    e.err = err; e.rdata = rdata; e.cyc = 32'(cyc + lat - 1);
    exp_q.push_back(e);
    for (int k = 0; k < 12; k++) begin
      if (exp_q.size() == 0 && acc_q.size() == 0) break;
      @(negedge clk);
    end
    chk("drain_timeout", 32'(exp_q.size() + acc_q.size()), 0);
    exp_q.delete();
    acc_q.delete();
  endtask

  // Monitor: responses, memory accesses, idle/hold behaviour and reset values.
  always @(negedge clk) begin
    resp_t e;
    acc_t  a;
    if (!rst_n) begin
      chk("rst_resp_flags", {30'b0, resp_valid, resp_err}, 0);
      chk("rst_rdata", resp_rdata, 0);
      chk("rst_mem_ctl", 32'({mem_we, mem_wstrb, mem_addr}), 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      last_rdata = '0;
      last_err   = 1'b0;
    end else begin
      if (resp_valid) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_resp: got resp_valid=1 expected none at cycle %0d", cyc);
        end else begin
          e = exp_q.pop_front();
          chk("resp_rdata", resp_rdata, e.rdata);
          chk("resp_err", resp_err, e.err);
          chk("resp_latency", 32'(cyc), e.cyc);
          last_rdata = e.rdata;
          last_err   = e.err;
        end
      end else begin
        chk("resp_hold_rdata", resp_rdata, last_rdata);
        chk("resp_hold_err", resp_err, last_err);
      end
      if (dbg_state == 2'd1 || dbg_state == 2'd2) begin
        if (acc_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_access: got addr=%h we=%b strb=%b expected none", mem_addr, mem_we, mem_wstrb);
        end else begin
          a = acc_q.pop_front();
          chk("mem_addr", 32'(mem_addr), 32'(a.addr));
          chk("mem_we", 32'(mem_we), 32'(a.we));
          chk("mem_wstrb", 32'(mem_wstrb), 32'(a.strb));
          chk("mem_wdata", mem_wdata, a.wdata);
        end
      end else begin
        chk("mem_idle_ctl", 32'({mem_we, mem_wstrb, mem_addr}), 0);
        chk("mem_idle_wdata", mem_wdata, 0);
      end
    end
  end

  // Stimulus
  initial begin
    logic [31:0] w;
    logic [31:0] addr;
    logic [1:0]  size;
    int          r;
    acc_t        a;
    for (int i = 0; i < 256; i++) begin
      w = $urandom;
      mem_words[i] = w;
      for (int j = 0; j < 4; j++) ref_mem[4*i + j] = w[8*j +: 8];
    end
    mem_words[1] = 32'h8070F0A5;
    ref_mem[4] = 8'hA5; ref_mem[5] = 8'hF0; ref_mem[6] = 8'h70; ref_mem[7] = 8'h80;

    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;

    issue(1'b1, 2'd2, 1'b0, 32'h008, 32'hDEADBEEF);
    issue(1'b0, 2'd2, 1'b0, 32'h008, 32'h0);
    issue(1'b0, 2'd0, 1'b0, 32'h005, 32'h0);
    issue(1'b0, 2'd0, 1'b1, 32'h005, 32'h0);
    issue(1'b0, 2'd1, 1'b0, 32'h006, 32'h0);
    issue(1'b1, 2'd1, 1'b0, 32'h00E, 32'h00001234);
    issue(1'b0, 2'd1, 1'b1, 32'h00E, 32'h0);
    issue(1'b1, 2'd2, 1'b0, 32'h000, 32'h44332211);
    issue(1'b1, 2'd2, 1'b0, 32'h004, 32'h88776655);
    issue(1'b0, 2'd2, 1'b0, 32'h003, 32'h0);
    issue(1'b0, 2'd1, 1'b0, 32'h003, 32'h0);
    issue(1'b1, 2'd1, 1'b0, 32'h007, 32'h0000ABCD);
    issue(1'b0, 2'd2, 1'b0, 32'h004, 32'h0);
    issue(1'b0, 2'd2, 1'b0, 32'h400, 32'h0);
    issue(1'b0, 2'd3, 1'b0, 32'h010, 32'h0);
    issue(1'b1, 2'd3, 1'b0, 32'h010, 32'hFFFFFFFF);
    issue(1'b0, 2'd0, 1'b0, 32'h3FF, 32'h0);
    issue(1'b0, 2'd1, 1'b0, 32'h3FF, 32'h0);
    issue(1'b0, 2'd2, 1'b0, 32'h3FC, 32'h0);

    // Store abandoned by a reset during its first access cycle
    @(negedge clk);
    w = $urandom;
    a.we = 1'b1; a.addr = 10'h010; a.strb = 4'b1111; a.wdata = w;
    acc_q.push_back(a);
    req_we = 1'b1; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 32'h010; req_wdata = w;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    chk("rst_acc_consumed", 32'(acc_q.size()), 0);
    acc_q.delete();
    issue(1'b0, 2'd2, 1'b0, 32'h010, 32'h0);
    issue(1'b0, 2'd2, 1'b0, 32'h008, 32'h0);

    for (int n = 0; n < 250; n++) begin
      r    = $urandom_range(0, 9);
      size = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
      r    = $urandom_range(0, 11);
      if (r == 0)      addr = 32'h400 + $urandom_range(0, 255);
      else if (r == 1) addr = $urandom;
      else if (r == 2) addr = $urandom_range(1020, 1023);
      else             addr = $urandom_range(0, 1023);
      if ($urandom_range(0, 1) == 1 && size != 2'd3)
        addr = addr & ~((32'd1 << size) - 32'd1);
      issue(1'($urandom_range(0, 1)), size, 1'($urandom_range(0, 1)), addr, $urandom);
    end

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lsu_dmem_master.md
LSU_DMEM_MASTER -- requirements
Module: lsu_dmem_master

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, the byte-address width of the data memory port.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, the data width (only 32 supported).
REQ-003 SHALL have clk, input, 1, clock; all state updates on posedge.
REQ-004 SHALL have rst_n, input, 1, reset, asynchronous, active-low.
REQ-005 SHALL have req_valid (in, 1) and req_ready (out, 1), the core request handshake.
REQ-006 SHALL have req_we (in, 1), 1=store, 0=load.
REQ-007 SHALL have req_size (in, 2): 00=byte, 01=half, 10=word, 11=illegal.
REQ-008 SHALL have req_unsigned (in, 1), which selects zero-extension for loads.
REQ-009 SHALL have req_addr (in, 32) as the byte address and req_wdata (in, 32) as the store data, LSB-aligned.
REQ-010 SHALL have resp_valid (out, 1), resp_rdata (out, 32) and resp_err (out, 1).
REQ-011 SHALL have the memory-side ports mem_we (out, 1), mem_addr (out, ADDR_WIDTH), mem_wdata (out, 32), mem_wstrb (out, 4) and mem_rdata (in, 32). The memory read is combinational when mem_we=0, and the write commits on posedge.

Function
REQ-012 SHALL implement FSM states IDLE, ACC0, ACC1, RESP, with req_ready=1 only in IDLE.
REQ-013 SHALL, in IDLE on req_valid&&req_ready, register all req_* fields and go to ACC0, or go to RESP with the error flag set if the request is erroneous.
REQ-014 SHALL treat a request as erroneous if req_size=11, if any req_addr bit at or above ADDR_WIDTH is set in any accessed byte, or if it is misaligned with the feature disabled (REQ-030).
REQ-015 SHALL make no memory access for an erroneous request: mem_we=0 and mem_wstrb=0 throughout.
REQ-016 SHALL, in ACC0, drive mem_addr = {addr[ADDR_WIDTH-1:2],2'b00}, mem_we=req_we, and mem_wstrb = the lanes (offset .. min(offset+bytes-1, 3)).
REQ-017 SHALL drive store data as mem_wdata = req_wdata << 8*offset; lanes outside mem_wstrb are don't-care but SHALL be driven 0.
REQ-018 SHALL, for a load in ACC0, drive mem_wstrb=0 and capture mem_rdata at the end of ACC0.
REQ-019 SHALL go from ACC0 to ACC1 if the access crosses a word boundary, otherwise to RESP.
REQ-020 SHALL, in ACC1, access word address +4 with lanes 0..(remaining bytes-1), store data = the upper req_wdata bytes shifted down, and load bytes captured into the upper result bytes; then go to RESP.
REQ-021 SHALL, for loads, form the result from the captured bytes >> 8*offset, sign- or zero-extended from size per req_unsigned; word loads are passed through unchanged.
REQ-022 SHALL, in RESP, assert resp_valid for exactly one cycle, with resp_err as flagged and resp_rdata = the load result (0 for stores and errors); the next state is IDLE.
REQ-023 SHALL hold resp_rdata and resp_err stable outside RESP at their last values.
REQ-024 SHALL drive mem_we, mem_wstrb, mem_addr and mem_wdata to 0 in IDLE and RESP.
REQ-025 SHALL have a latency of resp_valid 2 cycles after the accept edge (3 with split, 1 for error) and SHALL NOT accept a new request during RESP.

Reset
REQ-026 SHALL, on rst_n low, immediately force state=IDLE and all outputs to 0 except req_ready=1 after release.
REQ-027 SHALL, on a reset during ACC0 or ACC1, abandon the access with no resp_valid pulse; a store in ACC1 leaves the first half written.
REQ-028 SHALL clear all captured request/data registers to 0 on reset.

Configuration
REQ-029 SHALL, with macro LSU_MISALIGN_EN defined, support misaligned half/word accesses: in-word accesses use one access, word-crossing accesses split per REQ-020.
REQ-030 SHALL, without LSU_MISALIGN_EN, treat addr not a multiple of the size as erroneous (resp_err=1, no access) and omit the ACC1 state.

Verification
REQ-031 SHALL cover: word store addr 0x008 data 0xDEADBEEF -> in ACC0 mem_addr=0x008, mem_wstrb=1111, mem_we=1; resp_valid 2 cycles after accept, resp_err=0.
REQ-032 SHALL cover: memory word at 0x004 = 0x8070F0A5, signed byte load addr 0x005 -> resp_rdata=0xFFFFFFF0; the unsigned equivalent -> 0x000000F0.
REQ-033 SHALL cover: half store addr 0x00E data 0x1234 -> mem_wstrb=1100, mem_wdata=0x12340000.
REQ-034 SHALL cover: word load addr 0x003 with words 0x000=0x44332211 and 0x004=0x88776655, macro defined -> accesses to 0x000 then 0x004, resp_rdata=0x77665544; macro undefined -> resp_err=1 one cycle after accept, no mem access.
REQ-035 SHALL cover: load addr 0x400 (ADDR_WIDTH=10), and separately req_size=11 -> resp_err=1, mem_we=0, resp_rdata=0.
REQ-036 SHALL cover: rst_n pulsed low during ACC0 of a store -> no resp_valid pulse, req_ready=1 after release, and a subsequent word load returns correct data.
